radiometer_core: RTL and testbench

Parametrised successor of the radiometer back-end. Generates the Dicke switching waveform and blanks samples after each switch edge. Synchronously demodulates N_CH ADC channels over a multi-cycle integration window, then serialises each result as a checksummed byte frame over a valid/ready handshake to a UART transmitter.

---
 rtl/radiometer_pkg.sv | 19 +
 rtl/radiometer_core_switch.sv | 64 ++++++
 rtl/radiometer_core.sv | 178 +++++++++++++++++
 tb/tb_radiometer_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radiometer_pkg.sv
// Shared types and constants for the radiometer back-end.
// Frame layout: sync, seq, N_CH*ACC_W/8 data bytes, checksum.
package radiometer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CSUM
    } ser_state_e;

    function automatic int frame_len(input int n_ch, input int acc_w);
        return 3 + n_ch * acc_w / 8;
    endfunction

endpackage

// File: rtl/radiometer_core_switch.sv
// Dicke switch timing: phase counter, switch output, blanking,
// arming on the reference-phase start and integration window end.
module dicke_switch_gen #(
    parameter int HALF_PERIOD = 50000,
    parameter int BLANK       = 1000,
    parameter int N_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic pwm_o,
    output logic open_o,
    output logic armed_o,
    output logic window_end_o
);

    localparam int CNT_W = $clog2(HALF_PERIOD);
    localparam int CYC_W = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             pwm_q, pwm_d;
    logic             armed_q, armed_d;
    logic             wrap, ref_start, armed, win_end;

    assign wrap      = (cnt_q == CNT_W'(HALF_PERIOD - 1));
    assign ref_start = (cnt_q == '0) && !pwm_q;
    // Arming takes effect on the reference-phase start cycle itself.
    assign armed     = enable && (armed_q || ref_start);
    assign win_end   = wrap && pwm_q && armed
                       && (cyc_q == CYC_W'(N_CYCLES - 1));

    always_comb begin
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        pwm_d   = wrap ? ~pwm_q : pwm_q;
        armed_d = armed;
        cyc_d   = cyc_q;
        if (!armed || win_end) begin
            cyc_d = '0;
        end else if (wrap && pwm_q) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            armed_q <= 1'b0;
            cyc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            armed_q <= armed_d;
            cyc_q   <= cyc_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign open_o       = (cnt_q >= CNT_W'(BLANK));
    assign armed_o      = armed;
    assign window_end_o = win_end;

endmodule

// File: rtl/radiometer_core.sv
// Radiometer back-end: synchronous demodulation of N_CH channels
// and checksummed byte-frame serialisation to a UART.
module radiometer_core
    import radiometer_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int ADC_W       = 12,
    parameter int ACC_W       = 32,
    parameter int HALF_PERIOD = 50000,
    parameter int BLANK       = 1000,
    parameter int N_CYCLES    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic [N_CH*ADC_W-1:0]   sample_data,
    output logic                    switch_pwm,
    output logic                    demod_valid,
    output logic [N_CH*ACC_W-1:0]   demod,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    frame_busy,
    output logic                    overrun
);

    localparam int DB = frame_len(N_CH, ACC_W) - 3;
    localparam int SW = N_CH * ACC_W;
    localparam int IW = $clog2(DB + 1);

    logic pwm, open_w, armed, window_end, accept, hs;

    dicke_switch_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .BLANK       (BLANK),
        .N_CYCLES    (N_CYCLES)
    ) u_switch (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_o        (pwm),
        .open_o       (open_w),
        .armed_o      (armed),
        .window_end_o (window_end)
    );

    logic [N_CH-1:0][ACC_W-1:0] acc_sig_q, acc_sig_d;
    logic [N_CH-1:0][ACC_W-1:0] acc_ref_q, acc_ref_d;
    logic [SW-1:0]              diff_d, ord_d, demod_q, sh_q;
    logic                       demod_valid_q;
    logic [7:0]                 seq_q, seqb_q, csum_q, tx_data_q;
    logic                       tx_valid_q, overrun_q;
    logic [IW-1:0]              idx_q;
    ser_state_e                 state_q;

    assign accept = sample_valid && armed && open_w;
    assign hs     = tx_valid_q && tx_ready;

    always_comb begin
        acc_sig_d = acc_sig_q;
        acc_ref_d = acc_ref_q;
        diff_d    = '0;
        ord_d     = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (accept && pwm) begin
                acc_sig_d[ch] = acc_sig_q[ch]
                    + ACC_W'(sample_data[ch*ADC_W +: ADC_W]);
            end
            if (accept && !pwm) begin
                acc_ref_d[ch] = acc_ref_q[ch]
                    + ACC_W'(sample_data[ch*ADC_W +: ADC_W]);
            end
            diff_d[ch*ACC_W +: ACC_W] = acc_sig_d[ch] - acc_ref_d[ch];
            // ch0 lands in the top word so a left shift emits it first.
            ord_d[(N_CH-1-ch)*ACC_W +: ACC_W] =
                demod_q[ch*ACC_W +: ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable || window_end) begin
            acc_sig_q <= '0;
            acc_ref_q <= '0;
        end else begin
            acc_sig_q <= acc_sig_d;
            acc_ref_q <= acc_ref_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            demod_q       <= '0;
            demod_valid_q <= 1'b0;
            seq_q         <= '0;
        end else begin
            demod_valid_q <= window_end;
            if (window_end) begin
                demod_q <= diff_d;
            end
            if (demod_valid_q) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            sh_q       <= '0;
            seqb_q     <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (demod_valid_q && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (demod_valid_q) begin
                        sh_q       <= ord_d;
                        seqb_q     <= seq_q;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (hs) begin
                        tx_data_q <= seqb_q;
                        csum_q    <= seqb_q;
                        state_q   <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (hs) begin
                        tx_data_q <= sh_q[SW-1 -: 8];
                        sh_q      <= sh_q << 8;
                        idx_q     <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        csum_q <= csum_q ^ tx_data_q;
                        if (idx_q == IW'(DB - 1)) begin
                            tx_data_q <= csum_q ^ tx_data_q;
                            state_q   <= S_CSUM;
                        end else begin
                            tx_data_q <= sh_q[SW-1 -: 8];
                            sh_q      <= sh_q << 8;
                            idx_q     <= idx_q + IW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (hs) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign switch_pwm  = pwm;
    assign demod_valid = demod_valid_q;
    assign demod       = demod_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign frame_busy  = (state_q != S_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_radiometer_core.sv
// Testbench for radiometer_core: vector table of windows plus
// hand-written stall, overrun, re-arm and reset sequences.
module tb_radiometer_core;

    logic        clk = 1'b0;
    logic        rst, enable, sample_valid, tx_ready;
    logic [23:0] sample_data;
    logic        switch_pwm, demod_valid, tx_valid;
    logic        frame_busy, overrun;
    logic [31:0] demod;
    logic [7:0]  tx_data;

    logic [11:0] s0, r0, s1, r1;
    assign sample_data = switch_pwm ? {s1, s0} : {r1, r0};

    radiometer_core #(
        .N_CH (2), .ADC_W (12), .ACC_W (16),
        .HALF_PERIOD (8), .BLANK (2), .N_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .switch_pwm   (switch_pwm),
        .demod_valid  (demod_valid),
        .demod        (demod),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_busy   (frame_busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] s0, r0, s1, r1;
        logic [15:0] d0, d1;
        logic [7:0]  cs;
    } vec_t;

    vec_t       tv [4];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic       sb_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_dv(input int lim, output int n);
        n = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            n++;
            if (demod_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL dv_timeout: got none expected demod_valid");
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] xcs(input logic [7:0] sq,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
        return sq ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0];
    endfunction

    task automatic push_frame(input logic [7:0] sq,
                              input logic [15:0] a,
                              input logic [15:0] b,
                              input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(sq);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
        exp_q.push_back(cs);
    endtask

    task automatic set_vec(input vec_t v);
        s0 = v.s0; r0 = v.r0; s1 = v.s1; r1 = v.r1;
    endtask

    task automatic chk_demod(input logic [15:0] a,
                             input logic [15:0] b);
        chk("demod_ch0", demod[15:0], a);
        chk("demod_ch1", demod[31:16], b);
    endtask

    initial begin
        #100us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] e;
        tv[0] = '{12'd100, 12'd40, 12'd5, 12'd10,
                  16'h02D0, 16'hFFC4, 8'hE9};
        tv[1] = '{12'd100, 12'd40, 12'd5, 12'd10,
                  16'h02D0, 16'hFFC4, 8'hE8};
        tv[2] = '{12'd4095, 12'd0, 12'd0, 12'd4095,
                  16'hBFF4, 16'h400C, 8'h05};
        tv[3] = '{12'd0, 12'd0, 12'd7, 12'd7,
                  16'h0000, 16'h0000, 8'h03};

        fork
            forever begin
                @(negedge clk);
                if (sb_en && tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got %h expected none",
                                 tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_data, e);
                    end
                end
            end
        join_none

        set_vec(tv[0]);
        rst = 1'b1; enable = 1'b1; sample_valid = 1'b1;
        tx_ready = 1'b1; sb_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pwm", switch_pwm, 0);
        chk("rst_dv", demod_valid, 0);
        chk("rst_demod", demod, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wait_dv(200, n);
            chk("win_len", n, (i == 0) ? 32 : 31);
            chk_demod(tv[i].d0, tv[i].d1);
            push_frame(8'(i), tv[i].d0, tv[i].d1, tv[i].cs);
            set_vec(tv[(i + 1) % 4]);
            @(negedge clk);
            chk("dv_pulse", demod_valid, 0);
        end

        // Stall mid-DATA: byte must hold while ready is low.
        wait_dv(200, n);
        chk("win_len", n, 31);
        chk_demod(16'h02D0, 16'hFFC4);
        push_frame(8'd4, 16'h02D0, 16'hFFC4,
                   xcs(8'd4, 16'h02D0, 16'hFFC4));
        repeat (4) @(posedge clk);
        #1 tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, exp_q[0]);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        drain();

        // Two windows finish while the first frame is stuck.
        wait_dv(200, n);
        tx_ready = 1'b0;
        chk_demod(16'h02D0, 16'hFFC4);
        push_frame(8'd5, 16'h02D0, 16'hFFC4,
                   xcs(8'd5, 16'h02D0, 16'hFFC4));
        wait_dv(200, n);
        chk("win_len", n, 32);
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", frame_busy, 1);
        chk("ovr_hold", tx_data, 8'hA5);
        wait_dv(200, n);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        chk("ovr_idle", frame_busy, 0);
        chk("ovr_sticky", overrun, 1);

        // Drop enable mid-window; re-arms at next ref start.
        wait_dv(200, n);
        chk_demod(16'h02D0, 16'hFFC4);
        push_frame(8'd8, 16'h02D0, 16'hFFC4,
                   xcs(8'd8, 16'h02D0, 16'hFFC4));
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        wait_dv(200, n);
        chk("rearm_len", n, 34);
        chk_demod(16'h02D0, 16'hFFC4);

        // Reset while the seq byte is on the wire.
        sb_en = 1'b0;
        @(negedge clk);
        chk("pre_sync", tx_data, 8'hA5);
        @(negedge clk);
        chk("pre_seq", tx_data, 8'd9);
        chk("pre_txv", tx_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_txv", tx_valid, 0);
        chk("mid_pwm", switch_pwm, 0);
        chk("mid_busy", frame_busy, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_demod", demod, 0);
        rst = 1'b0;
        sb_en = 1'b1;
        wait_dv(200, n);
        chk("win_len", n, 32);
        chk_demod(tv[0].d0, tv[0].d1);
        push_frame(8'd0, tv[0].d0, tv[0].d1, tv[0].cs);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
